mux_rr_arbiter: RTL

Round-robin arbiter that shares one `bits`-wide output channel among `depth` valid/ready requesters. It steers requester data through an internal `mux_parametrizable` instance into a registered output stage. Each cycle it grants at most one requester and exports the last granted index on `mux_sel_o` for debug and for external muxes. It sits between the per-source producers and the single downstream consumer.

---
 rtl/mux_arb_pkg.sv | 37 +++
 rtl/mux_parametrizable.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search used by the valid/ready arbiter.
package mux_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    localparam int unsigned MAX_DEPTH = 64;
    localparam int unsigned IDX_W     = $clog2(MAX_DEPTH);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_result_t;

    // First set bit of req at or after last+1, wrapping at depth; depth <= MAX_DEPTH.
    function automatic rr_result_t rr_next(input logic [MAX_DEPTH-1:0] req,
                                           input int unsigned          last,
                                           input int unsigned          depth);
        rr_result_t  res;
        int unsigned n;
        res = '0;
        n   = 0;
        for (int unsigned k = 1; k <= MAX_DEPTH; k++) begin
            if (k <= depth && !res.found) begin
                n = last + k;
                if (n >= depth) begin
                    n = n - depth;
                end
                if (req[IDX_W'(n)]) begin
                    res.found = 1'b1;
                    res.idx   = IDX_W'(n);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_parametrizable.sv
// Plain N:1 data selector; out-of-range selects produce zero.
module mux_parametrizable #(
    parameter int unsigned depth = 16,
    parameter int unsigned bits  = 8
) (
    input  logic [$clog2(depth):0] mux_sel_i,
    input  logic [bits-1:0]        data_i [depth],
    output logic [bits-1:0]        mux_data_o
);

    localparam int unsigned SEL_W = $clog2(depth) + 1;

    always_comb begin
        mux_data_o = '0;
        for (int unsigned n = 0; n < depth; n++) begin
            if (mux_sel_i == SEL_W'(n)) begin
                mux_data_o = data_i[n];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered output channel among depth requesters.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned depth = 16,
    parameter int unsigned bits  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [depth-1:0]       req_valid_i,
    input  logic [bits-1:0]        req_data_i [depth],
    output logic [depth-1:0]       req_ready_o,
    output logic                   out_valid_o,
    output logic [bits-1:0]        out_data_o,
    input  logic                   out_ready_i,
    output logic [$clog2(depth):0] mux_sel_o
);

    localparam int unsigned SEL_W = $clog2(depth) + 1;

    arb_state_e           state_q;
    logic [SEL_W-1:0]     last_grant_q;
    logic [SEL_W-1:0]     mux_sel_q;
    logic [bits-1:0]      out_data_q;
    logic                 out_valid_q;

    logic [MAX_DEPTH-1:0] req_pad;
    rr_result_t           rr_res;
    logic                 load;
    logic                 xfer;
    logic [SEL_W-1:0]     win_sel_d;
    logic [bits-1:0]      win_data_d;

    // Winner search and grant; reset suppresses any handshake.
    always_comb begin
        req_pad              = '0;
        req_pad[depth-1:0]   = req_valid_i;
        rr_res               = rr_next(req_pad, 32'(last_grant_q), depth);
        load                 = (state_q == ARB_IDLE) || out_ready_i;
        xfer                 = load && rr_res.found && !rst_i;
        win_sel_d            = SEL_W'(rr_res.idx);
        req_ready_o          = '0;
        for (int unsigned n = 0; n < depth; n++) begin
            req_ready_o[n] = xfer && (rr_res.idx == IDX_W'(n));
        end
    end

    mux_parametrizable #(
        .depth (depth),
        .bits  (bits)
    ) u_mux (
        .mux_sel_i  (win_sel_d),
        .data_i     (req_data_i),
        .mux_data_o (win_data_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= SEL_W'(depth - 1);
            mux_sel_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else if (xfer) begin
            state_q      <= ARB_HOLD;
            last_grant_q <= win_sel_d;
            mux_sel_q    <= win_sel_d;
            out_data_q   <= win_data_d;
            out_valid_q  <= 1'b1;
        end else if (state_q == ARB_HOLD && out_ready_i) begin
            // Consumer drained the word and nothing is pending.
            state_q      <= ARB_IDLE;
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign mux_sel_o   = mux_sel_q;

endmodule
